// File: rtl/board_renderer.sv
// Playfield renderer: maps hcount/vcount onto a COLS x ROWS cell grid, fetches the cell index from board RAM and resolves it through a palette.
// Latency 2 vclk from hcount/vcount to pixel_board; cell_data is sampled in the cycle cell_addr is presented; no backpressure.
module board_renderer #(
    parameter int          H_ORIGIN   = 92,
    parameter int          V_ORIGIN   = 0,
    parameter int          CELL_W     = 32,
    parameter int          CELL_H     = 30,
    parameter int          COLS       = 10,
    parameter int          ROWS       = 20,
    parameter int          IDX_W      = 3,
    parameter int          ADDR_W     = 8,
    parameter logic [7:0]  GRID_COLOR = 8'h49
) (
    input  logic              vclk,
    input  logic              rst_n,
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    input  logic              grid_en,
    output logic [ADDR_W-1:0] cell_addr,
    input  logic [IDX_W-1:0]  cell_data,
    input  logic              pal_we,
    input  logic [IDX_W-1:0]  pal_idx,
    input  logic [7:0]        pal_color,
    output logic [7:0]        pixel_board,
    output logic              frame_done
);
    localparam int XW   = $clog2(CELL_W);
    localparam int YW   = $clog2(CELL_H);
    localparam int NPAL = 2**IDX_W;

    localparam logic [11:0]       LP_H_LO   = 12'(H_ORIGIN);
    localparam logic [11:0]       LP_H_HI   = 12'(H_ORIGIN + COLS*CELL_W);
    localparam logic [10:0]       LP_V_LO   = 11'(V_ORIGIN);
    localparam logic [10:0]       LP_V_HI   = 11'(V_ORIGIN + ROWS*CELL_H);
    localparam logic [XW-1:0]     LP_X_LAST = XW'(CELL_W - 1);
    localparam logic [YW-1:0]     LP_Y_LAST = YW'(CELL_H - 1);
    localparam logic [ADDR_W-1:0] LP_COLS   = ADDR_W'(COLS);

    logic [XW-1:0]     r_x_sub;
    logic [ADDR_W-1:0] r_col;
    logic [YW-1:0]     r_y_sub;
    logic [ADDR_W-1:0] r_row_base;
    logic              r_in_board_d;
    logic              r_edge_d;
    logic [7:0]        r_pal [NPAL];

    logic [11:0]       w_h;
    logic [10:0]       w_v;
    logic              w_h_start;
    logic              w_line_start;
    logic              w_in_board;
    logic              w_edge;
    logic [XW-1:0]     w_x_sub;
    logic [ADDR_W-1:0] w_col;
    logic [YW-1:0]     w_y_sub;
    logic [ADDR_W-1:0] w_row_base;

    assign w_h          = {1'b0, hcount};
    assign w_v          = {1'b0, vcount};
    assign w_h_start    = (w_h == LP_H_LO);
    assign w_line_start = (w_h == 12'd0);

    // Counters are forwarded combinationally so the clearing cycle itself already sees the new position.
    assign w_x_sub = w_h_start ? '0 : r_x_sub;
    assign w_col   = w_h_start ? '0 : r_col;

    always_comb begin
        w_y_sub    = r_y_sub;
        w_row_base = r_row_base;
        if (w_line_start) begin
            if (w_v == LP_V_LO) begin
                w_y_sub    = '0;
                w_row_base = '0;
            end else if (w_v > LP_V_LO && w_v < LP_V_HI) begin
                if (r_y_sub == LP_Y_LAST) begin
                    w_y_sub    = '0;
                    w_row_base = r_row_base + LP_COLS;
                end else begin
                    w_y_sub = r_y_sub + 1'b1;
                end
            end
        end
    end

    assign w_in_board = (w_h >= LP_H_LO) && (w_h < LP_H_HI) && (w_v >= LP_V_LO) && (w_v < LP_V_HI);
    assign w_edge     = grid_en && ((w_x_sub == LP_X_LAST) || (w_y_sub == LP_Y_LAST));

    always_ff @(posedge vclk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_sub      <= '0;
            r_col        <= '0;
            r_y_sub      <= '0;
            r_row_base   <= '0;
            r_in_board_d <= 1'b0;
            r_edge_d     <= 1'b0;
            cell_addr    <= '0;
            frame_done   <= 1'b0;
            pixel_board  <= 8'h00;
        end else begin
            r_x_sub      <= (w_x_sub == LP_X_LAST) ? '0 : w_x_sub + 1'b1;
            r_col        <= (w_x_sub == LP_X_LAST) ? w_col + 1'b1 : w_col;
            r_y_sub      <= w_y_sub;
            r_row_base   <= w_row_base;
            r_in_board_d <= w_in_board;
            r_edge_d     <= w_edge;
            cell_addr    <= w_in_board ? (w_row_base + w_col) : '0;
            frame_done   <= w_line_start && (w_v == LP_V_HI);
            // Outside the board the RAM data is ignored so an unwritten RAM cannot leak X.
            if (!r_in_board_d)
                pixel_board <= 8'h00;
            else if (r_edge_d)
                pixel_board <= GRID_COLOR;
            else
                pixel_board <= r_pal[cell_data];
        end
    end

    always_ff @(posedge vclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NPAL; k++)
                r_pal[k] <= (k == 0) ? 8'h00 : 8'h97;
        end else if (pal_we) begin
            r_pal[pal_idx] <= pal_color;
        end
    end
endmodule
